vga_fetch_sched: RTL and testbench

//  Schedules framebuffer read bursts feeding the VGA pixel FIFO. Walks base_addr..top_addr from the config unit,

---
 rtl/vga_fetch_sched_pkg.sv | 18 +
 rtl/vga_fetch_sched_len_queue.sv | 62 ++++++
 rtl/vga_fetch_sched.sv | 174 +++++++++++++++++
 tb/tb_vga_fetch_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fetch_sched_pkg.sv
// Shared types and constants for the VGA framebuffer fetch scheduler.
// State encoding, burst length width and beat shift helper.
package vga_fetch_sched_pkg;

  localparam int LEN_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic int beat_shift(input int bytes);
    return $clog2(bytes);
  endfunction

endpackage

// File: rtl/vga_fetch_sched_len_queue.sv
// Length queue of outstanding bursts with a beat countdown for the head
// burst; flags burst_done on the last beat and ignores beats with none open.
module vga_fetch_sched_len_queue
  import vga_fetch_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 push,
  input  logic [LEN_WIDTH-1:0] push_len,
  input  logic                 beat,
  output logic                 beat_ok,
  output logic                 burst_done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [LEN_WIDTH-1:0] lens [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;
  logic [LEN_WIDTH-1:0] rcvd;
  logic [LEN_WIDTH-1:0] rcvd_nxt;

  assign rcvd_nxt   = LEN_WIDTH'(rcvd + 1'b1);
  assign beat_ok    = beat && (count != '0);
  assign burst_done = beat_ok && (rcvd_nxt == lens[rd_ptr]);

  always_ff @(posedge clk) begin
    if (push) begin
      lens[wr_ptr] <= push_len;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rcvd   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : PTR_W'(wr_ptr + 1'b1);
      end
      if (burst_done) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : PTR_W'(rd_ptr + 1'b1);
        rcvd   <= '0;
      end else if (beat_ok) begin
        rcvd <= rcvd_nxt;
      end
      unique case ({push, burst_done})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_fetch_sched.sv
// Framebuffer read-burst scheduler for the VGA pixel FIFO.
// Optional VGA_FETCH_PERF_EN adds stall and frame performance counters.
module vga_fetch_sched
  import vga_fetch_sched_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int BEAT_BYTES      = 4,
  parameter int BURST_LEN       = 16,
  parameter int FIFO_DEPTH      = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable_i,
  input  logic                          frame_start_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr_i,
  input  logic [ADDR_WIDTH-1:0]         top_addr_i,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_level_i,
  output logic                          rd_req_valid_o,
  input  logic                          rd_req_ready_i,
  output logic [ADDR_WIDTH-1:0]         rd_req_addr_o,
  output logic [LEN_WIDTH-1:0]          rd_req_len_o,
  input  logic                          rd_data_valid_i,
  output logic                          busy_o,
  output logic                          cfg_err_o
`ifdef VGA_FETCH_PERF_EN
  ,
  output logic [31:0]                   perf_stall_cnt_o,
  output logic [15:0]                   perf_frame_cnt_o
`endif
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = LVL_W + LEN_WIDTH + 1;
  localparam int AW1   = ADDR_WIDTH + 1;
  localparam int BS    = beat_shift(BEAT_BYTES);
  localparam logic [ADDR_WIDTH-1:0] BL_M1 = ADDR_WIDTH'(BURST_LEN - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] top_q;
  logic [LVL_W-1:0]      in_flight;
  logic [OUT_W-1:0]      outstanding;

  logic [ADDR_WIDTH-1:0] span;
  logic [LEN_WIDTH-1:0]  len_calc;
  logic [SUM_W-1:0]      need;
  logic [AW1-1:0]        step;
  logic [AW1-1:0]        next_addr;
  logic                  wrap;
  logic                  can_issue;
  logic                  stop;
  logic                  hs;
  logic                  beat_ok;
  logic                  burst_done;

  assign span     = (top_q - addr) >> BS;
  assign len_calc = (span >= BL_M1) ? LEN_WIDTH'(BURST_LEN)
                                    : LEN_WIDTH'(span + 1'b1);

  assign need = SUM_W'(fifo_level_i) + SUM_W'(in_flight)
              + SUM_W'(len_calc);

  assign can_issue = (outstanding < OUT_W'(MAX_OUTSTANDING))
                  && (need <= SUM_W'(FIFO_DEPTH));

  assign step      = AW1'(rd_req_len_o) << BS;
  assign next_addr = {1'b0, rd_req_addr_o} + step;
  assign wrap      = next_addr > {1'b0, top_q};

  assign stop   = frame_start_i | ~enable_i;
  assign hs     = rd_req_valid_o & rd_req_ready_i;
  assign busy_o = (state != ST_IDLE);

  vga_fetch_sched_len_queue #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_len_queue (
    .clk        (clk),
    .resetn     (resetn),
    .push       (hs),
    .push_len   (rd_req_len_o),
    .beat       (rd_data_valid_i),
    .beat_ok    (beat_ok),
    .burst_done (burst_done)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      in_flight   <= '0;
      outstanding <= '0;
    end else begin
      in_flight <= in_flight
                 + (hs ? LVL_W'(rd_req_len_o) : '0)
                 - (beat_ok ? LVL_W'(1) : '0);
      unique case ({hs, burst_done})
        2'b10:   outstanding <= OUT_W'(outstanding + 1'b1);
        2'b01:   outstanding <= OUT_W'(outstanding - 1'b1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      addr           <= '0;
      base_q         <= '0;
      top_q          <= '0;
      rd_req_valid_o <= 1'b0;
      rd_req_addr_o  <= '0;
      rd_req_len_o   <= '0;
      cfg_err_o      <= 1'b0;
    end else begin
      if (hs) begin
        rd_req_valid_o <= 1'b0;
        addr <= wrap ? base_q : next_addr[ADDR_WIDTH-1:0];
      end
      unique case (state)
        ST_IDLE: begin
          if (enable_i && frame_start_i) begin
            state <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (top_addr_i < base_addr_i) begin
            cfg_err_o <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cfg_err_o <= 1'b0;
            base_q    <= base_addr_i;
            top_q     <= top_addr_i;
            addr      <= base_addr_i;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (stop) begin
            state <= ST_DRAIN;
          end else if (!rd_req_valid_o && can_issue) begin
            rd_req_valid_o <= 1'b1;
            rd_req_addr_o  <= addr;
            rd_req_len_o   <= len_calc;
          end
        end
        ST_DRAIN: begin
          // a held request still has to be accepted before leaving
          if (!rd_req_valid_o && outstanding == '0) begin
            state <= enable_i ? ST_ARM : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef VGA_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_stall_cnt_o <= '0;
      perf_frame_cnt_o <= '0;
    end else begin
      if (state == ST_ISSUE && !can_issue) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
      if (state == ST_ARM && top_addr_i >= base_addr_i) begin
        perf_frame_cnt_o <= perf_frame_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_fetch_sched.sv
// Scoreboard bench for vga_fetch_sched: directed frames, throttling,
// wrap, config error and reset-with-bursts-outstanding scenarios.
module tb_vga_fetch_sched;

  logic        clk;
  logic        resetn;
  logic        enable_i;
  logic        frame_start_i;
  logic [31:0] base_addr_i;
  logic [31:0] top_addr_i;
  logic [8:0]  fifo_level_i;
  logic        rd_req_valid_o;
  logic        rd_req_ready_i;
  logic [31:0] rd_req_addr_o;
  logic [7:0]  rd_req_len_o;
  logic        rd_data_valid_i;
  logic        busy_o;
  logic        cfg_err_o;
`ifdef VGA_FETCH_PERF_EN
  logic [31:0] perf_stall_cnt_o;
  logic [15:0] perf_frame_cnt_o;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  l;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   beats_pending = 0;
  int   stray_n = 0;
  logic mem_en = 1'b1;
  logic ready_en = 1'b1;

  vga_fetch_sched dut (
    .clk             (clk),
    .resetn          (resetn),
    .enable_i        (enable_i),
    .frame_start_i   (frame_start_i),
    .base_addr_i     (base_addr_i),
    .top_addr_i      (top_addr_i),
    .fifo_level_i    (fifo_level_i),
    .rd_req_valid_o  (rd_req_valid_o),
    .rd_req_ready_i  (rd_req_ready_i),
    .rd_req_addr_o   (rd_req_addr_o),
    .rd_req_len_o    (rd_req_len_o),
    .rd_data_valid_i (rd_data_valid_i),
    .busy_o          (busy_o),
    .cfg_err_o       (cfg_err_o)
`ifdef VGA_FETCH_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_frame_cnt_o (perf_frame_cnt_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [7:0] l);
    exp_t e;
    e.a = a;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input string name, input int bound);
    int c = 0;
    while (exp_q.size() != 0 && c < bound) begin
      @(negedge clk);
      c++;
    end
    chk(name, exp_q.size(), 0);
    step(1);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int c = 0;
    while (busy_o && c < bound) begin
      @(negedge clk);
      c++;
    end
    chk(name, {31'd0, busy_o}, 0);
    step(1);
  endtask

  task automatic start_frame();
    enable_i = 1'b1;
    frame_start_i = 1'b1;
    step(1);
    frame_start_i = 1'b0;
  endtask

  task automatic chk_held(input string name, input logic [31:0] a,
                          input logic [7:0] l);
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, rd_req_valid_o}, 1);
    chk({name, "_addr"}, rd_req_addr_o, a);
    chk({name, "_len"}, {24'd0, rd_req_len_o}, {24'd0, l});
    step(1);
  endtask

  // request acceptor: ready only while the scoreboard expects something
  initial begin
    rd_req_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rd_req_ready_i = ready_en && (exp_q.size() > 0);
    end
  end

  initial begin
    rd_data_valid_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stray_n > 0) begin
        rd_data_valid_i = 1'b1;
        stray_n--;
      end else if (mem_en && beats_pending > 0) begin
        rd_data_valid_i = 1'b1;
        beats_pending--;
      end else begin
        rd_data_valid_i = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && rd_req_valid_o && rd_req_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req actual=%h/%0d required=none",
                   rd_req_addr_o, rd_req_len_o);
        end else begin
          e = exp_q.pop_front();
          chk("req_addr", rd_req_addr_o, e.a);
          chk("req_len", {24'd0, rd_req_len_o}, {24'd0, e.l});
        end
        beats_pending += int'(rd_req_len_o);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cap_a;
    logic [7:0]  cap_l;
    resetn = 1'b0;
    enable_i = 1'b0;
    frame_start_i = 1'b0;
    base_addr_i = 32'h1000;
    top_addr_i = 32'h10FC;
    fifo_level_i = 9'd0;
    step(3);
    chk("rst_valid", {31'd0, rd_req_valid_o}, 0);
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_err", {31'd0, cfg_err_o}, 0);
    chk("rst_addr", rd_req_addr_o, 0);
    chk("rst_len", {24'd0, rd_req_len_o}, 0);
    resetn = 1'b1;
    step(2);

    // full frame walk with wrap back to base
    push(32'h1000, 8'd16);
    push(32'h1040, 8'd16);
    push(32'h1080, 8'd16);
    push(32'h10C0, 8'd16);
    push(32'h1000, 8'd16);
    push(32'h1040, 8'd16);
    start_frame();
    step(1);
    chk("t1_busy", {31'd0, busy_o}, 1);
    wait_empty("t1_drain", 400);
    step(40);
    chk_held("t1_held", 32'h1080, 8'd16);
    push(32'h1080, 8'd16);
    step(2);
    enable_i = 1'b0;
    wait_idle("t1_idle", 400);

    // truncated burst at top, never crosses it
    top_addr_i = 32'h1020;
    push(32'h1000, 8'd9);
    push(32'h1000, 8'd9);
    push(32'h1000, 8'd9);
    start_frame();
    wait_empty("t2_drain", 400);
    step(40);
    chk_held("t2_held", 32'h1000, 8'd9);
    push(32'h1000, 8'd9);
    step(2);
    enable_i = 1'b0;
    wait_idle("t2_idle", 400);

    // FIFO space throttle
    top_addr_i = 32'h10FC;
    fifo_level_i = 9'd245;
    mem_en = 1'b0;
    start_frame();
    step(10);
    chk("t3_blocked", {31'd0, rd_req_valid_o}, 0);
    push(32'h1000, 8'd16);
    step(1);
    fifo_level_i = 9'd240;
    @(negedge clk);
    chk("t3_lat0", {31'd0, rd_req_valid_o}, 0);
    @(negedge clk);
    chk("t3_lat1", {31'd0, rd_req_valid_o}, 1);
    step(10);
    chk("t3_full", {31'd0, rd_req_valid_o}, 0);
    chk("t3_q", exp_q.size(), 0);
    enable_i = 1'b0;
    mem_en = 1'b1;
    wait_idle("t3_idle", 400);
    fifo_level_i = 9'd0;

    // held request survives frame_start, then drain and re-arm at base
    ready_en = 1'b0;
    push(32'h1000, 8'd16);
    push(32'h1000, 8'd16);
    start_frame();
    step(2);
    @(negedge clk);
    cap_a = rd_req_addr_o;
    cap_l = rd_req_len_o;
    chk("t4_valid", {31'd0, rd_req_valid_o}, 1);
    chk("t4_addr", cap_a, 32'h1000);
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (i == 4) begin
        frame_start_i = 1'b1;
      end else begin
        frame_start_i = 1'b0;
      end
      @(negedge clk);
      chk("t4_stable",
          {rd_req_valid_o, (rd_req_addr_o == cap_a), (rd_req_len_o == cap_l)},
          3'b111);
    end
    step(1);
    frame_start_i = 1'b0;
    ready_en = 1'b1;
    step(3);
    chk("t4_drain_busy", {31'd0, busy_o}, 1);
    wait_empty("t4_rearm", 400);
    step(40);
    chk_held("t4_held", 32'h1040, 8'd16);
    push(32'h1040, 8'd16);
    step(2);
    enable_i = 1'b0;
    wait_idle("t4_idle", 400);

    // bad config, then fixed config
    base_addr_i = 32'h2000;
    top_addr_i = 32'h1000;
    start_frame();
    step(5);
    chk("t5_err", {31'd0, cfg_err_o}, 1);
    chk("t5_busy", {31'd0, busy_o}, 0);
    chk("t5_valid", {31'd0, rd_req_valid_o}, 0);
    top_addr_i = 32'h20FC;
    push(32'h2000, 8'd16);
    start_frame();
    step(3);
    chk("t5_err_clr", {31'd0, cfg_err_o}, 0);
    wait_empty("t5_drain", 400);
    step(40);
    chk_held("t5_held", 32'h2040, 8'd16);
    push(32'h2040, 8'd16);
    step(2);
    enable_i = 1'b0;
    wait_idle("t5_idle", 400);

    // reset with bursts outstanding, then stray beats
    base_addr_i = 32'h1000;
    top_addr_i = 32'h10FC;
    mem_en = 1'b0;
    push(32'h1000, 8'd16);
    push(32'h1040, 8'd16);
    push(32'h1080, 8'd16);
    start_frame();
    wait_empty("t6_issue", 400);
    step(5);
    resetn = 1'b0;
    enable_i = 1'b0;
    beats_pending = 0;
    stray_n = 3;
    step(1);
    @(negedge clk);
    chk("t6_rst_valid", {31'd0, rd_req_valid_o}, 0);
    chk("t6_rst_busy", {31'd0, busy_o}, 0);
    chk("t6_rst_addr", rd_req_addr_o, 0);
    step(3);
    resetn = 1'b1;
    stray_n = 3;
    step(6);
    chk("t6_stray_valid", {31'd0, rd_req_valid_o}, 0);
    chk("t6_stray_busy", {31'd0, busy_o}, 0);
    push(32'h1000, 8'd16);
    push(32'h1040, 8'd16);
    push(32'h1080, 8'd16);
    push(32'h10C0, 8'd16);
    start_frame();
    wait_empty("t6_four", 400);
    step(20);
    chk("t6_credit_cap", {31'd0, rd_req_valid_o}, 0);
    enable_i = 1'b0;
    mem_en = 1'b1;
    wait_idle("t6_idle", 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
